renode_gpio_driver: RTL and testbench

Renode-to-HDL direction of the interrupt/GPIO line protocol. Accepts `interrupt` messages from the Renode connection layer through a valid/ready stream and buffers them in a small FIFO. Applies each message to an output line bank that drives HDL inputs such as external interrupt or GPIO pins. Returns one acknowledgement message per request. It complements the upstream block that reports HDL line changes to Renode; the message encoding is identical (data = line index, address = level).

---
 rtl/renode_pkg.sv | 43 ++++
 rtl/renode_msg_fifo.sv | 57 +++++
 rtl/renode_gpio_driver.sv | 155 +++++++++++++++
 tb/tb_renode_gpio_driver.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/renode_pkg.sv
// Shared types for the Renode <-> HDL message streams and the GPIO driver.
// The GPIO FSM enum gains a PULSE state when RENODE_GPIO_PULSE_EN is defined.
package renode_pkg;

  typedef enum logic [7:0] {
    invalid      = 8'd0,
    tickClock    = 8'd1,
    writeRequest = 8'd2,
    readRequest  = 8'd3,
    reset        = 8'd4,
    interrupt    = 8'd5,
    ok           = 8'd6,
    error        = 8'd7
  } action_e;

  typedef logic [63:0] address_t;
  typedef logic [63:0] data_t;

`ifdef RENODE_GPIO_PULSE_EN
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_APPLY = 2'd1,
    ST_PULSE = 2'd2,
    ST_ACK   = 2'd3
  } gpio_state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_APPLY = 2'd1,
    ST_ACK   = 2'd3
  } gpio_state_e;
`endif

  typedef struct packed {
    action_e  action;
    address_t address;
    data_t    data;
  } gpio_req_t;

  localparam int LevelBit = 0;
  localparam int PulseBit = 1;

endpackage

// File: rtl/renode_msg_fifo.sv
// Small request FIFO: array storage, registered read port updated on pop.
// Depth must be a power of two so the pointers wrap naturally.
module renode_msg_fifo #(
  parameter int Width = 8,
  parameter int Depth = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [Width-1:0] i_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [Width-1:0] o_data
);

  localparam int AW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [Width-1:0] r_mem [Depth];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic [Width-1:0] r_rd_data;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == (AW+1)'(Depth));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_data  = r_rd_data;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_rd_data <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop) begin
        r_rd_ptr  <= r_rd_ptr + AW'(1);
        r_rd_data <= r_mem[r_rd_ptr];
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/renode_gpio_driver.sv
// Applies Renode interrupt messages to a bank of driven lines, one ack per request.
// Optional pulse mode (address bit1) is enabled by defining RENODE_GPIO_PULSE_EN.
module renode_gpio_driver
  import renode_pkg::*;
#(
  parameter int                    LinesCount  = 1,
  parameter int                    FifoDepth   = 4,
  parameter logic [LinesCount-1:0] ResetValue  = '0,
  parameter int                    PulseCycles = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  msg_valid,
  output logic                  msg_ready,
  input  action_e               msg_action,
  input  address_t              msg_address,
  input  data_t                 msg_data,
  output logic                  ack_valid,
  input  logic                  ack_ready,
  output action_e               ack_action,
  output data_t                 ack_data,
  output logic [LinesCount-1:0] lines,
  output logic                  error_pulse
);

  gpio_state_e           r_state;
  logic [LinesCount-1:0] r_lines;
  logic                  r_ack_valid;
  action_e               r_ack_action;
  data_t                 r_ack_data;
  logic                  r_error_pulse;

  gpio_req_t             w_req_in;
  gpio_req_t             w_cur;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_pop;
  logic                  w_accept;
  logic [LinesCount-1:0] w_sel;
  logic                  w_level;

  assign w_req_in  = '{action: msg_action, address: msg_address, data: msg_data};
  assign msg_ready = !w_full;
  assign w_pop     = (r_state == ST_IDLE) && !w_empty;

  renode_msg_fifo #(
    .Width ($bits(gpio_req_t)),
    .Depth (FifoDepth)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (msg_valid && !w_full),
    .i_pop   (w_pop),
    .i_data  (w_req_in),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_data  (w_cur)
  );

  // Full-width index compare: out-of-range indices can never alias a real line.
  generate
    for (genvar gi = 0; gi < LinesCount; gi++) begin : g_sel
      assign w_sel[gi] = (w_cur.data == data_t'(gi));
    end
  endgenerate

  assign w_accept = (w_cur.action == interrupt) && (w_cur.data < data_t'(LinesCount));
  assign w_level  = w_cur.address[LevelBit];

`ifdef RENODE_GPIO_PULSE_EN
  localparam int CW = (PulseCycles > 1) ? $clog2(PulseCycles) : 1;
  logic [CW-1:0] r_pulse_cnt;
  logic          w_unused_addr;
  assign w_unused_addr = ^w_cur.address[63:2];
`else
  localparam int unused_pulse_cycles = PulseCycles;
  logic          w_unused_addr;
  assign w_unused_addr = ^w_cur.address[63:1];
`endif

  // The FIFO read register holds the current request until the next pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_lines       <= ResetValue;
      r_ack_valid   <= 1'b0;
      r_ack_action  <= ok;
      r_ack_data    <= '0;
      r_error_pulse <= 1'b0;
`ifdef RENODE_GPIO_PULSE_EN
      r_pulse_cnt   <= '0;
`endif
    end else begin
      r_error_pulse <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (!w_empty) r_state <= ST_APPLY;
        end
        ST_APPLY: begin
          r_ack_data <= w_cur.data;
          if (w_accept) begin
            for (int i = 0; i < LinesCount; i++) begin
              if (w_sel[i]) r_lines[i] <= w_level;
            end
            r_ack_action <= ok;
`ifdef RENODE_GPIO_PULSE_EN
            if (w_cur.address[PulseBit]) begin
              r_pulse_cnt <= CW'(PulseCycles - 1);
              r_state     <= ST_PULSE;
            end else begin
              r_ack_valid <= 1'b1;
              r_state     <= ST_ACK;
            end
`else
            r_ack_valid <= 1'b1;
            r_state     <= ST_ACK;
`endif
          end else begin
            r_error_pulse <= 1'b1;
            r_ack_action  <= error;
            r_ack_valid   <= 1'b1;
            r_state       <= ST_ACK;
          end
        end
`ifdef RENODE_GPIO_PULSE_EN
        ST_PULSE: begin
          if (r_pulse_cnt == '0) begin
            for (int i = 0; i < LinesCount; i++) begin
              if (w_sel[i]) r_lines[i] <= !w_level;
            end
            r_ack_valid <= 1'b1;
            r_state     <= ST_ACK;
          end else begin
            r_pulse_cnt <= r_pulse_cnt - CW'(1);
          end
        end
`endif
        ST_ACK: begin
          if (ack_ready) begin
            r_ack_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign lines       = r_lines;
  assign ack_valid   = r_ack_valid;
  assign ack_action  = r_ack_action;
  assign ack_data    = r_ack_data;
  assign error_pulse = r_error_pulse;

endmodule

// File: tb/tb_renode_gpio_driver.sv
// Directed bench for renode_gpio_driver (LinesCount=4, FifoDepth=4, PulseCycles=3).
// Pulse expectations follow RENODE_GPIO_PULSE_EN.
module tb_renode_gpio_driver;
  import renode_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       msg_valid;
  logic       msg_ready;
  action_e    msg_action;
  address_t   msg_address;
  data_t      msg_data;
  logic       ack_valid;
  logic       ack_ready;
  action_e    ack_action;
  data_t      ack_data;
  logic [3:0] lines;
  logic       error_pulse;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  renode_gpio_driver #(
    .LinesCount  (4),
    .FifoDepth   (4),
    .ResetValue  (4'b0000),
    .PulseCycles (3)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .msg_valid   (msg_valid),
    .msg_ready   (msg_ready),
    .msg_action  (msg_action),
    .msg_address (msg_address),
    .msg_data    (msg_data),
    .ack_valid   (ack_valid),
    .ack_ready   (ack_ready),
    .ack_action  (ack_action),
    .ack_data    (ack_data),
    .lines       (lines),
    .error_pulse (error_pulse)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Request is accepted on the next edge; returns 1 time unit after it.
  task automatic send(input action_e a, input address_t ad, input data_t d);
    msg_action  = a;
    msg_address = ad;
    msg_data    = d;
    msg_valid   = 1'b1;
    $display("txn push act=%s addr=%0h data=%0h", a.name(), ad, d);
    tick();
    msg_valid = 1'b0;
  endtask

  task automatic wait_ack(output bit got);
    got = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if (ack_valid) begin
        got = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic take_ack;
    $display("txn ack act=%s data=%0h", ack_action.name(), ack_data);
    ack_ready = 1'b1;
    tick();
    ack_ready = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (lines !== 4'b0000) begin n_mis++; $display("FAIL reset_lines got=%b exp=0000", lines); end
    n_cmp++; if (msg_ready !== 1'b1) begin n_mis++; $display("FAIL reset_msg_ready got=%b exp=1", msg_ready); end
    n_cmp++; if (ack_valid !== 1'b0) begin n_mis++; $display("FAIL reset_ack_valid got=%b exp=0", ack_valid); end
    n_cmp++; if (ack_action !== ok) begin n_mis++; $display("FAIL reset_ack_action got=%0d exp=%0d", ack_action, ok); end
    n_cmp++; if (ack_data !== 64'd0) begin n_mis++; $display("FAIL reset_ack_data got=%0h exp=0", ack_data); end
    n_cmp++; if (error_pulse !== 1'b0) begin n_mis++; $display("FAIL reset_error_pulse got=%b exp=0", error_pulse); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_level_write;
    send(interrupt, 64'd1, 64'd2);
    n_cmp++; if (ack_valid !== 1'b0 || lines !== 4'b0000) begin n_mis++; $display("FAIL level_n0 got=%b/%b exp=0/0000", ack_valid, lines); end
    tick();
    n_cmp++; if (ack_valid !== 1'b0 || lines !== 4'b0000) begin n_mis++; $display("FAIL level_n1 got=%b/%b exp=0/0000", ack_valid, lines); end
    tick();
    n_cmp++; if (lines !== 4'b0100) begin n_mis++; $display("FAIL level_lines got=%b exp=0100", lines); end
    n_cmp++; if (ack_valid !== 1'b1) begin n_mis++; $display("FAIL level_ack_valid got=%b exp=1", ack_valid); end
    n_cmp++; if (ack_action !== ok || ack_data !== 64'd2) begin n_mis++; $display("FAIL level_ack got=%0d/%0h exp=%0d/2", ack_action, ack_data, ok); end
    n_cmp++; if (error_pulse !== 1'b0) begin n_mis++; $display("FAIL level_no_err got=%b exp=0", error_pulse); end
    tick();
    n_cmp++; if (ack_valid !== 1'b1 || ack_data !== 64'd2) begin n_mis++; $display("FAIL level_ack_hold got=%b/%0h exp=1/2", ack_valid, ack_data); end
    take_ack();
    n_cmp++; if (ack_valid !== 1'b0) begin n_mis++; $display("FAIL level_ack_done got=%b exp=0", ack_valid); end
  endtask

  task automatic test_bad_index;
    send(interrupt, 64'd1, 64'd7);
    tick();
    n_cmp++; if (error_pulse !== 1'b0) begin n_mis++; $display("FAIL badidx_err_early got=%b exp=0", error_pulse); end
    tick();
    n_cmp++; if (error_pulse !== 1'b1) begin n_mis++; $display("FAIL badidx_err got=%b exp=1", error_pulse); end
    n_cmp++; if (lines !== 4'b0100) begin n_mis++; $display("FAIL badidx_lines got=%b exp=0100", lines); end
    n_cmp++; if (ack_valid !== 1'b1 || ack_action !== error || ack_data !== 64'd7) begin n_mis++; $display("FAIL badidx_ack got=%b/%0d/%0h exp=1/%0d/7", ack_valid, ack_action, ack_data, error); end
    tick();
    n_cmp++; if (error_pulse !== 1'b0) begin n_mis++; $display("FAIL badidx_err_len got=%b exp=0", error_pulse); end
    take_ack();
  endtask

  task automatic test_wrong_action;
    bit got;
    send(reset, 64'd1, 64'd1);
    wait_ack(got);
    n_cmp++; if (!got) begin n_mis++; $display("FAIL wrongact_timeout got=no_ack exp=ack"); end
    n_cmp++; if (ack_action !== error || ack_data !== 64'd1) begin n_mis++; $display("FAIL wrongact_ack got=%0d/%0h exp=%0d/1", ack_action, ack_data, error); end
    n_cmp++; if (lines !== 4'b0100) begin n_mis++; $display("FAIL wrongact_lines got=%b exp=0100", lines); end
    take_ack();
  endtask

  task automatic test_wide_index;
    bit got;
    send(interrupt, 64'd1, 64'h1_0000_0001);
    wait_ack(got);
    n_cmp++; if (!got) begin n_mis++; $display("FAIL wideidx_timeout got=no_ack exp=ack"); end
    n_cmp++; if (ack_action !== error || ack_data !== 64'h1_0000_0001) begin n_mis++; $display("FAIL wideidx_ack got=%0d/%0h exp=%0d/100000001", ack_action, ack_data, error); end
    n_cmp++; if (lines !== 4'b0100) begin n_mis++; $display("FAIL wideidx_lines got=%b exp=0100", lines); end
    take_ack();
  endtask

  task automatic test_pulse;
    bit got;
    send(interrupt, 64'd3, 64'd0);
    repeat (2) tick();
    n_cmp++; if (lines !== 4'b0101) begin n_mis++; $display("FAIL pulse_rise got=%b exp=0101", lines); end
`ifdef RENODE_GPIO_PULSE_EN
    n_cmp++; if (ack_valid !== 1'b0) begin n_mis++; $display("FAIL pulse_ack_early got=%b exp=0", ack_valid); end
    repeat (2) begin
      tick();
      n_cmp++; if (lines !== 4'b0101 || ack_valid !== 1'b0) begin n_mis++; $display("FAIL pulse_hold got=%b/%b exp=0101/0", lines, ack_valid); end
    end
    tick();
    n_cmp++; if (lines !== 4'b0100) begin n_mis++; $display("FAIL pulse_fall got=%b exp=0100", lines); end
    n_cmp++; if (ack_valid !== 1'b1 || ack_action !== ok || ack_data !== 64'd0) begin n_mis++; $display("FAIL pulse_ack got=%b/%0d/%0h exp=1/%0d/0", ack_valid, ack_action, ack_data, ok); end
    take_ack();
`else
    n_cmp++; if (ack_valid !== 1'b1 || ack_action !== ok || ack_data !== 64'd0) begin n_mis++; $display("FAIL pulse_ack got=%b/%0d/%0h exp=1/%0d/0", ack_valid, ack_action, ack_data, ok); end
    take_ack();
    repeat (3) tick();
    n_cmp++; if (lines !== 4'b0101) begin n_mis++; $display("FAIL pulse_level_stays got=%b exp=0101", lines); end
    send(interrupt, 64'd0, 64'd0);
    wait_ack(got);
    n_cmp++; if (!got || lines !== 4'b0100) begin n_mis++; $display("FAIL pulse_restore got=%b/%b exp=1/0100", got, lines); end
    take_ack();
`endif
  endtask

  task automatic test_back_to_back;
    int   first_c  = -1;
    int   second_c = -1;
    data_t d1 = '0;
    data_t d2 = '0;
    ack_ready = 1'b1;
    send(interrupt, 64'd1, 64'd1);
    msg_action  = interrupt;
    msg_address = 64'd1;
    msg_data    = 64'd3;
    msg_valid   = 1'b1;
    $display("txn push act=interrupt addr=1 data=3");
    tick();
    msg_valid = 1'b0;
    for (int c = 2; c <= 10; c++) begin
      tick();
      if (ack_valid) begin
        $display("txn ack act=%s data=%0h", ack_action.name(), ack_data);
        if (first_c < 0) begin first_c = c; d1 = ack_data; end
        else if (second_c < 0) begin second_c = c; d2 = ack_data; end
      end
    end
    ack_ready = 1'b0;
    n_cmp++; if (first_c != 2 || d1 !== 64'd1) begin n_mis++; $display("FAIL b2b_first got=c%0d/%0h exp=c2/1", first_c, d1); end
    n_cmp++; if (second_c != 5 || d2 !== 64'd3) begin n_mis++; $display("FAIL b2b_second got=c%0d/%0h exp=c5/3", second_c, d2); end
    n_cmp++; if (lines !== 4'b1110) begin n_mis++; $display("FAIL b2b_lines got=%b exp=1110", lines); end
  endtask

  task automatic test_back_pressure;
    bit got;
    bit extra;
    logic [63:0] idx [5] = '{64'd0, 64'd1, 64'd2, 64'd3, 64'd0};
    logic [63:0] lvl [5] = '{64'd1, 64'd0, 64'd1, 64'd0, 64'd0};
    ack_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (msg_ready !== 1'b1) begin n_mis++; $display("FAIL bp_ready_%0d got=%b exp=1", i, msg_ready); end
      msg_action  = interrupt;
      msg_address = lvl[i];
      msg_data    = idx[i];
      msg_valid   = 1'b1;
      $display("txn push act=interrupt addr=%0h data=%0h", lvl[i], idx[i]);
      tick();
    end
    msg_address = 64'd1;
    msg_data    = 64'd5;
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (msg_ready !== 1'b0) begin n_mis++; $display("FAIL bp_full_%0d got=%b exp=0", i, msg_ready); end
      tick();
    end
    msg_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wait_ack(got);
      n_cmp++; if (!got || ack_action !== ok || ack_data !== idx[i]) begin n_mis++; $display("FAIL bp_ack_%0d got=%b/%0d/%0h exp=1/%0d/%0h", i, got, ack_action, ack_data, ok, idx[i]); end
      take_ack();
    end
    extra = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (ack_valid) extra = 1'b1;
      tick();
    end
    n_cmp++; if (extra) begin n_mis++; $display("FAIL bp_extra_ack got=ack exp=none"); end
    n_cmp++; if (lines !== 4'b0100) begin n_mis++; $display("FAIL bp_lines got=%b exp=0100", lines); end
  endtask

  task automatic test_reset_mid_ack;
    bit got;
    bit bad;
    ack_ready = 1'b0;
    send(interrupt, 64'd1, 64'd3);
    send(interrupt, 64'd1, 64'd0);
    send(interrupt, 64'd1, 64'd1);
    wait_ack(got);
    n_cmp++; if (!got || lines !== 4'b1100) begin n_mis++; $display("FAIL rstmid_pre got=%b/%b exp=1/1100", got, lines); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (lines !== 4'b0000) begin n_mis++; $display("FAIL rstmid_lines got=%b exp=0000", lines); end
    n_cmp++; if (ack_valid !== 1'b0) begin n_mis++; $display("FAIL rstmid_ack_valid got=%b exp=0", ack_valid); end
    n_cmp++; if (ack_action !== ok || ack_data !== 64'd0 || msg_ready !== 1'b1) begin n_mis++; $display("FAIL rstmid_outs got=%0d/%0h/%b exp=%0d/0/1", ack_action, ack_data, msg_ready, ok); end
    repeat (2) tick();
    rst_n = 1'b1;
    ack_ready = 1'b1;
    bad = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (ack_valid || lines !== 4'b0000) bad = 1'b1;
    end
    ack_ready = 1'b0;
    n_cmp++; if (bad) begin n_mis++; $display("FAIL rstmid_after got=activity exp=idle"); end
  endtask

  initial begin
    msg_valid   = 1'b0;
    msg_action  = invalid;
    msg_address = '0;
    msg_data    = '0;
    ack_ready   = 1'b0;
    test_reset();
    test_level_write();
    test_bad_index();
    test_wrong_action();
    test_wide_index();
    test_pulse();
    test_back_to_back();
    test_back_pressure();
    test_reset_mid_ack();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
